// File: rtl/idu_pkg.sv
// Shared types, opcode constants and small decode helpers for the
// instruction-decode pipeline stage.
package idu_pkg;

    localparam int ILEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd_addr;
        logic        rd_wen;
        alu_op_t     alu_op;
        logic        lsu_ren;
        logic        lsu_wen;
        logic [2:0]  lsu_op;
        logic        csr_wen;
        logic [11:0] csr_addr;
        logic        is_branch;
        logic        is_jump;
        logic        illegal;
    } dec_bundle_t;

    function automatic logic is_known_opcode(input logic [6:0] opc);
        logic known;
        known = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_SYSTEM: known = 1'b1;
            default: known = 1'b0;
        endcase
        return known;
    endfunction

    // SUB only exists in register form; SRA/SRAI share funct7 bit 5.
    function automatic alu_op_t alu_op_of(input logic [2:0] funct3,
                                          input logic       funct7_b5,
                                          input logic       is_reg);
        alu_op_t op;
        op = ALU_ADD;
        case (funct3)
            3'b000:  op = (is_reg && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Purely combinational RV32I immediate extraction, sign-extended to XLEN.
// Register-form and unrecognised encodings yield zero.
module imm_gen
    import idu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (inst[6:0])
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_SYSTEM:
                imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
            OPC_STORE:
                imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
            OPC_BRANCH:
                imm = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {inst[31:12], 12'b0};
            OPC_JAL:
                imm = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/idu_pipe.sv
// Instruction decode stage: decodes the offered instruction combinationally
// and stores the finished bundle in a small circular output FIFO.
module idu_pipe
    import idu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [31:0]                in_inst,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       in_ready,
    output logic [4:0]                 rs1_addr,
    output logic [4:0]                 rs2_addr,
    input  logic [XLEN-1:0]            rs1_data,
    input  logic [XLEN-1:0]            rs2_data,
    input  logic                       flush,
    output logic                       out_valid,
    output dec_bundle_t                out_bundle,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd_field;
    logic [XLEN-1:0] imm_w;
    logic            legal;
    logic            csr_op;
    logic            writes_rd;
    dec_bundle_t     dec;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_en_q, ready_en_d;
    logic             push;
    logic             pop;
    dec_bundle_t      mem_q [DEPTH];

    assign opcode   = in_inst[6:0];
    assign funct3   = in_inst[14:12];
    assign rd_field = in_inst[11:7];
    assign rs1_addr = in_inst[19:15];
    assign rs2_addr = in_inst[24:20];

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst (in_inst),
        .imm  (imm_w)
    );

    assign legal  = is_known_opcode(opcode) & (in_inst[1:0] == 2'b11);
    // funct3 == 0 under SYSTEM is ECALL/EBREAK/MRET; funct3 == 4 is reserved.
    assign csr_op = (opcode == OPC_SYSTEM) & (funct3[1:0] != 2'b00);

    always_comb begin
        dec           = '0;
        writes_rd     = 1'b0;
        dec.pc        = in_pc;
        dec.inst      = in_inst;
        dec.rs1_data  = rs1_data;
        dec.rs2_data  = rs2_data;
        dec.imm       = imm_w;
        dec.rd_addr   = rd_field;
        dec.lsu_op    = funct3;
        dec.csr_addr  = in_inst[31:20];
        dec.alu_op    = ALU_ADD;
        case (opcode)
            OPC_LUI: begin
                writes_rd  = 1'b1;
                dec.alu_op = ALU_PASSB;
            end
            OPC_AUIPC, OPC_LOAD: writes_rd = 1'b1;
            OPC_JAL, OPC_JALR: begin
                writes_rd   = 1'b1;
                dec.is_jump = 1'b1;
            end
            OPC_BRANCH: dec.is_branch = 1'b1;
            OPC_OP: begin
                writes_rd  = 1'b1;
                dec.alu_op = alu_op_of(funct3, in_inst[30], 1'b1);
            end
            OPC_OPIMM: begin
                writes_rd  = 1'b1;
                dec.alu_op = alu_op_of(funct3, in_inst[30], 1'b0);
            end
            OPC_SYSTEM: writes_rd = csr_op;
            default: writes_rd = 1'b0;
        endcase
        dec.illegal = ~legal;
        dec.rd_wen  = writes_rd & legal & (rd_field != 5'd0);
        dec.lsu_ren = legal & (opcode == OPC_LOAD);
        dec.lsu_wen = legal & (opcode == OPC_STORE);
        // CSRRS/CSRRC with rs1 = x0 only read the CSR.
        dec.csr_wen = legal & csr_op & ((funct3[1:0] == 2'b01) | (rs1_addr != 5'd0));
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    // ready_en_q keeps in_ready low during reset and until the first edge after it.
    assign in_ready  = ready_en_q & (count_q < DEPTH_C) & ~flush;
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign occupancy = count_q;
    assign out_bundle = mem_q[head_q];

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        ready_en_d = 1'b1;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = ptr_inc(tail_q);
            if (pop)  head_d = ptr_inc(head_q);
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ready_en_q <= ready_en_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= dec;
    end

endmodule

// File: tb/tb_idu_pipe.sv
// Randomised and directed bench for idu_pipe against a queue-based model
// that decodes instructions with plain arithmetic.
module tb_idu_pipe;
    import idu_pkg::*;

    localparam int DEPTH = 2;
    localparam int BW    = $bits(dec_bundle_t);

    logic                       clk;
    logic                       rst_n;
    logic                       in_valid;
    logic [31:0]                in_inst;
    logic [31:0]                in_pc;
    logic                       in_ready;
    logic [4:0]                 rs1_addr;
    logic [4:0]                 rs2_addr;
    logic [31:0]                rs1_data;
    logic [31:0]                rs2_data;
    logic                       flush;
    logic                       out_valid;
    dec_bundle_t                out_bundle;
    logic                       out_ready;
    logic [$clog2(DEPTH+1)-1:0] occupancy;

    logic [BW-1:0] exp_q[$];
    bit            ready_en_m;
    int            n_checks;
    int            n_err;
    bit            acc;

    idu_pipe #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .in_ready   (in_ready),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_bundle (out_bundle),
        .out_ready  (out_ready),
        .occupancy  (occupancy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference model: decode from the ISA rules
    function automatic dec_bundle_t ref_decode(input logic [31:0] i, input logic [31:0] pc,
                                               input logic [31:0] a, input logic [31:0] b);
        dec_bundle_t d;
        alu_op_t     tbl [8];
        logic [6:0]  opc;
        logic [2:0]  f3;
        bit          legal;
        bit          csr;
        bit          wr;
        int          v;
        opc = i[6:0];
        f3  = i[14:12];
        tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        d = '0;
        d.pc = pc; d.inst = i; d.rs1_data = a; d.rs2_data = b;
        d.rd_addr = i[11:7]; d.csr_addr = i[31:20]; d.lsu_op = f3;
        legal = (i[1:0] == 2'b11) && (opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                                                  OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_SYSTEM});
        d.illegal = !legal;
        case (opc)
            OPC_LUI, OPC_AUIPC: v = int'(i & 32'hFFFF_F000);
            OPC_JAL: v = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
                         + int'(i[30:21]) * 2;
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_SYSTEM: v = int'(i[31:20]) - (i[31] ? 4096 : 0);
            OPC_STORE: v = int'({i[31:25], i[11:7]}) - (i[31] ? 4096 : 0);
            OPC_BRANCH: v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32
                            + int'(i[11:8]) * 2;
            default: v = 0;
        endcase
        d.imm = v;
        if (opc == OPC_OP || opc == OPC_OPIMM) begin
            d.alu_op = tbl[f3];
            if (i[30] && f3 == 3'd5) d.alu_op = ALU_SRA;
            if (i[30] && f3 == 3'd0 && opc == OPC_OP) d.alu_op = ALU_SUB;
        end else if (opc == OPC_LUI) begin
            d.alu_op = ALU_PASSB;
        end else begin
            d.alu_op = ALU_ADD;
        end
        csr = (opc == OPC_SYSTEM) && (f3 != 3'd0) && (f3 != 3'd4);
        wr  = (opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OP}) || csr;
        d.rd_wen    = wr && legal && (i[11:7] != 0);
        d.lsu_ren   = legal && opc == OPC_LOAD;
        d.lsu_wen   = legal && opc == OPC_STORE;
        d.csr_wen   = legal && csr && (f3 == 3'd1 || f3 == 3'd5 || i[19:15] != 0);
        d.is_branch = (opc == OPC_BRANCH);
        d.is_jump   = (opc == OPC_JAL) || (opc == OPC_JALR);
        return d;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  opcs [10];
        logic [31:0] w;
        opcs = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                 OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_SYSTEM};
        w = $urandom;
        if ($urandom_range(0, 9) != 0) w[6:0] = opcs[$urandom_range(0, 9)];
        return w;
    endfunction

    // driver tasks
    task automatic new_offer();
        in_inst  = rand_inst();
        in_pc    = in_pc + 32'd4;
        rs1_data = $urandom;
        rs2_data = $urandom;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        exp_q.delete();
        ready_en_m = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_occupancy", occupancy, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("rel_in_ready_low", in_ready, 1'b0);
        @(posedge clk);
        ready_en_m = 1'b1;
        #1;
    endtask

    // One clock: sample at the falling edge, update scoreboard at the rising edge.
    task automatic cycle(output bit accepted);
        bit            pop_m;
        logic [BW-1:0] nb;
        @(negedge clk);
        check("occupancy", occupancy, exp_q.size());
        check("out_valid", out_valid, exp_q.size() != 0);
        check("in_ready", in_ready, ready_en_m && exp_q.size() < DEPTH && !flush);
        check("rs1_addr", rs1_addr, in_inst[19:15]);
        check("rs2_addr", rs2_addr, in_inst[24:20]);
        if (exp_q.size() != 0) check("head_bundle", out_bundle, exp_q[0]);
        accepted = in_valid && ready_en_m && exp_q.size() < DEPTH && !flush;
        pop_m    = (exp_q.size() != 0) && out_ready;
        nb       = ref_decode(in_inst, in_pc, rs1_data, rs2_data);
        @(posedge clk);
        if (flush) begin
            exp_q.delete();
        end else begin
            if (pop_m) void'(exp_q.pop_front());
            if (accepted) exp_q.push_back(nb);
        end
        ready_en_m = 1'b1;
        #1;
    endtask

    initial begin
        n_checks = 0; n_err = 0;
        in_valid = 0; in_inst = 0; in_pc = 32'h8000_0000; rs1_data = 0; rs2_data = 0;
        flush = 0; out_ready = 0; rst_n = 0;
        do_reset();

        // single ADDI x1, x2, -1
        in_inst = 32'hFFF1_0093; in_pc = 32'h8000_0000; rs1_data = 32'd5; rs2_data = $urandom;
        in_valid = 1'b1; out_ready = 1'b1;
        #1 check("addi_rs1_addr", rs1_addr, 5'd2);
        cycle(acc);
        in_valid = 1'b0;
        check("addi_out_valid", out_valid, 1'b1);
        check("addi_imm", out_bundle.imm, 32'hFFFF_FFFF);
        check("addi_rd_addr", out_bundle.rd_addr, 5'd1);
        check("addi_rd_wen", out_bundle.rd_wen, 1'b1);
        check("addi_illegal", out_bundle.illegal, 1'b0);
        check("addi_rs1_data", out_bundle.rs1_data, 32'd5);
        check("addi_pc", out_bundle.pc, 32'h8000_0000);
        cycle(acc);

        // fill with out_ready low, third offer must stall
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; new_offer();
        for (int k = 0; k < 3; k++) begin
            cycle(acc);
            if (acc) new_offer();
        end
        check("full_occupancy", occupancy, 2);
        check("full_in_ready", in_ready, 1'b0);

        // drain while offering: pointers wrap several times
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle(acc);
            if (acc) new_offer();
        end
        in_valid = 1'b0;
        repeat (3) cycle(acc);

        // flush beats a simultaneous offer
        out_ready = 1'b0; in_valid = 1'b1; new_offer();
        for (int k = 0; k < 2; k++) begin
            cycle(acc);
            if (acc) new_offer();
        end
        check("pre_flush_occ", occupancy, 2);
        flush = 1'b1; new_offer();
        cycle(acc);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_occ", occupancy, 0);
        check("flush_out_valid", out_valid, 1'b0);
        cycle(acc);

        // all-zero word and ECALL
        out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h0000_0000;
        cycle(acc);
        check("zero_illegal", out_bundle.illegal, 1'b1);
        check("zero_rd_wen", out_bundle.rd_wen, 1'b0);
        in_inst = 32'h0000_0073;
        cycle(acc);
        check("ecall_illegal", out_bundle.illegal, 1'b0);
        check("ecall_rd_wen", out_bundle.rd_wen, 1'b0);
        in_valid = 1'b0;
        cycle(acc);

        // asynchronous reset between edges with one entry held
        out_ready = 1'b0; in_valid = 1'b1; new_offer();
        cycle(acc);
        in_valid = 1'b0;
        check("pre_rst_occ", occupancy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", out_valid, 1'b0);
        check("async_in_ready", in_ready, 1'b0);
        exp_q.delete();
        ready_en_m = 1'b0;
        #1 rst_n = 1'b1;
        #1 check("post_rel_in_ready", in_ready, 1'b0);
        @(posedge clk);
        ready_en_m = 1'b1;
        #1;
        check("post_rel_occ", occupancy, 0);
        check("post_rel_ready_up", in_ready, 1'b1);

        // random traffic
        new_offer();
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            rs1_data  = $urandom;
            rs2_data  = $urandom;
            cycle(acc);
            if (acc || $urandom_range(0, 3) == 0) new_offer();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) cycle(acc);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
